// File: rtl/bus_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel bus deserializer.
//   deser_state_t : receive FSM states (IDLE, SHIFT, HOLD)
//   cnt_width()   : bits needed to count 0..WIDTH received bits
package bus_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bus_deserializer_if.sv
// Handshake bundle for the bus deserializer.
//   s_valid/s_ready/s_bit/s_last : single-bit serial input stream
//   m_valid/m_ready/m_data/m_err : assembled word output stream
// modport master : the environment (drives serial bits, consumes words)
// modport slave  : the deserializer itself
interface bus_deserializer_if #(
  parameter int WIDTH = 5
);

  logic             s_valid;
  logic             s_ready;
  logic             s_bit;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_err;

  modport master (
    output s_valid, s_bit, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );

  modport slave (
    input  s_valid, s_bit, s_last, m_ready,
    output s_ready, m_valid, m_data, m_err
  );

endinterface

// File: rtl/bus_shift_reg.sv
// Direction-selectable shift register for the deserializer.
//   clk, rst  : clock, asynchronous active-high reset
//   shift_i   : a serial bit is accepted this cycle
//   start_i   : the accepted bit begins a new frame (register cleared first)
//   bit_i     : serial data bit
//   cnt_i     : number of bits in the frame including the current one
//   word_o    : frame contents after the current bit, justified so that the
//               first stream bit sits at the end selected by MSB_FIRST and
//               any missing positions are zero
module bus_shift_reg
  import bus_deser_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MSB_FIRST = 1,
  parameter int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic             start_i,
  input  logic             bit_i,
  input  logic [CW-1:0]    cnt_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] base;
  logic [CW-1:0]    miss;

  // NOTE: every signal gets a value before any branch, so no latch is inferred.
  always_comb begin
    base = start_i ? '0 : sr_q;
    sr_d = base;
    if (MSB_FIRST != 0) begin
      sr_d = {base[WIDTH-2:0], bit_i};
    end else begin
      sr_d = {bit_i, base[WIDTH-1:1]};
    end
    // Short frames occupy only cnt_i positions; slide them to the first-bit end.
    miss = CW'(WIDTH) - cnt_i;
    if (MSB_FIRST != 0) begin
      word_o = sr_d << miss;
    end else begin
      word_o = sr_d >> miss;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/bus_deserializer.sv
// Serial-to-parallel bus deserializer with framing-error reporting.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of bus_deserializer_if (serial in, word out)
// Parameters: WIDTH (2..64) word width, MSB_FIRST selects whether the first
// received bit lands in m_data[WIDTH-1] (1) or m_data[0] (0).
module bus_deserializer
  import bus_deser_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MSB_FIRST = 1
) (
  input logic                clk,
  input logic                rst,
  bus_deserializer_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_t     state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             rdy_q;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_err_q;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             start;
  logic             done;
  logic             err_d;

  // rdy_q keeps s_ready low while reset is held and for the release edge;
  // in HOLD the consumer's ready passes straight through so a new bit can
  // be taken in the same cycle the held word leaves.
  assign bus.s_ready = (state_q == HOLD) ? bus.m_ready : rdy_q;
  assign accept      = bus.s_valid && bus.s_ready;
  assign start       = (state_q != SHIFT);
  assign cnt_d       = start ? CW'(1) : cnt_q + CW'(1);
  assign done        = accept && (bus.s_last || cnt_d == CW'(WIDTH));
  // Error when last comes early, or when the full word arrives without last.
  assign err_d       = (cnt_d != CW'(WIDTH)) || !bus.s_last;

  bus_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_i (accept),
    .start_i (start),
    .bit_i   (bus.s_bit),
    .cnt_i   (cnt_d),
    .word_o  (word)
  );

  // NOTE: the output word register is reset too, so m_data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        IDLE, SHIFT: ;
        HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // An accepted bit overrides the HOLD->IDLE exit: it starts or extends a frame.
      if (accept) begin
        if (done) begin
          state_q   <= HOLD;
          cnt_q     <= '0;
          m_valid_q <= 1'b1;
          m_data_q  <= word;
          m_err_q   <= err_d;
        end else begin
          state_q <= SHIFT;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_err   = m_err_q;

endmodule

// File: tb/tb_bus_deserializer.sv
// Self-checking bench: one MSB-first and one LSB-first instance share the
// same serial stimulus; a frame-level model predicts words and handshakes.
module tb_bus_deserializer;

  localparam int W = 5;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic s_valid = 1'b0;
  logic s_bit   = 1'b0;
  logic s_last  = 1'b0;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  bus_deserializer_if #(.WIDTH(W)) bus_m ();
  bus_deserializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.s_valid = s_valid;
  assign bus_m.s_bit   = s_bit;
  assign bus_m.s_last  = s_last;
  assign bus_m.m_ready = m_ready;
  assign bus_l.s_valid = s_valid;
  assign bus_l.s_bit   = s_bit;
  assign bus_l.s_last  = s_last;
  assign bus_l.m_ready = m_ready;

  bus_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  bus_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: words awaiting transfer and the partial frame.
  logic [W-1:0] pend_msb[$];
  logic [W-1:0] pend_lsb[$];
  bit           pend_err[$];
  bit           frame[$];
  bit           rdy_en    = 1'b0;
  int           cyc       = 0;
  int           last_xfer = -1;
  int           xfer_gap  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word built straight from stream order: bit i of the frame sits at
  // position W-1-i (MSB-first) or i (LSB-first); unfilled positions are zero.
  function automatic logic [W-1:0] mk_word(input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < frame.size(); i++) begin
      if (msb_first) w[W-1-i] = frame[i];
      else           w[i]     = frame[i];
    end
    return w;
  endfunction

  task automatic clear_model();
    pend_msb.delete();
    pend_lsb.delete();
    pend_err.delete();
    frame.delete();
    rdy_en = 1'b0;
  endtask

  // One clock with the currently driven inputs, checking both instances.
  task automatic step();
    bit exp_rdy;
    bit acc;
    bit xfer;
    bit dut_xfer;
    @(negedge clk);
    exp_rdy = rdy_en && !rst && (pend_msb.size() == 0 || m_ready);
    chk("s_ready_msb", bus_m.s_ready, exp_rdy);
    chk("s_ready_lsb", bus_l.s_ready, exp_rdy);
    acc      = s_valid && exp_rdy;
    xfer     = (pend_msb.size() != 0) && m_ready && !rst;
    dut_xfer = bus_m.m_valid && m_ready && !rst;
    @(posedge clk);
    cyc++;
    if (dut_xfer) begin
      xfer_gap  = cyc - last_xfer;
      last_xfer = cyc;
    end
    if (rst) begin
      clear_model();
    end else begin
      rdy_en = 1'b1;
      if (xfer) begin
        void'(pend_msb.pop_front());
        void'(pend_lsb.pop_front());
        void'(pend_err.pop_front());
      end
      if (acc) begin
        frame.push_back(s_bit);
        if (s_last || frame.size() == W) begin
          pend_msb.push_back(mk_word(1'b1));
          pend_lsb.push_back(mk_word(1'b0));
          pend_err.push_back(frame.size() != W || !s_last);
          frame.delete();
        end
      end
    end
    #1;
    chk("m_valid_msb", bus_m.m_valid, pend_msb.size() != 0);
    chk("m_valid_lsb", bus_l.m_valid, pend_msb.size() != 0);
    if (pend_msb.size() != 0) begin
      chk("m_data_msb", bus_m.m_data, pend_msb[0]);
      chk("m_data_lsb", bus_l.m_data, pend_lsb[0]);
      chk("m_err_msb", bus_m.m_err, pend_err[0]);
      chk("m_err_lsb", bus_l.m_err, pend_err[0]);
    end
  endtask

  task automatic send(input bit b, input bit l);
    s_valid = 1'b1;
    s_bit   = b;
    s_last  = l;
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_m_data", bus_m.m_data, 5'b00000);
    chk("rst_m_err", bus_m.m_err, 1'b0);
    rst = 1'b0;
    idle();
    chk("ready_after_release", bus_m.s_ready, 1'b1);

    // Basic frame: 1,0,1,1,0 with last on bit 5
    m_ready = 1'b1;
    send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(0, 1);
    chk("basic_msb", bus_m.m_data, 5'b10110);
    chk("basic_lsb", bus_l.m_data, 5'b01101);
    chk("basic_err", bus_m.m_err, 1'b0);

    // Back-to-back: a good frame then a frame missing its last flag
    send(0, 0); send(1, 0); send(1, 0); send(0, 0); send(1, 1);
    send(1, 0); send(1, 0); send(0, 0); send(0, 0); send(1, 0);
    chk("b2b_gap", xfer_gap, 5);
    chk("missing_last_err", bus_m.m_err, 1'b1);
    chk("missing_last_msb", bus_m.m_data, 5'b11001);

    // Backpressure: held word, bit offered but refused for 7 cycles
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(1, 1);
      chk("bp_stable", bus_m.m_data, 5'b11001);
    end
    // Release together with a 1-bit frame: hand-off and straight back to HOLD
    m_ready = 1'b1;
    send(1, 1);
    chk("one_bit_msb", bus_m.m_data, 5'b10000);
    chk("one_bit_lsb", bus_l.m_data, 5'b00001);
    chk("one_bit_err", bus_m.m_err, 1'b1);
    idle();

    // Early last: 1,1
    send(1, 0); send(1, 1);
    chk("early_msb", bus_m.m_data, 5'b11000);
    chk("early_lsb", bus_l.m_data, 5'b00011);
    chk("early_err", bus_m.m_err, 1'b1);
    idle();

    // Reset mid-frame after three bits
    send(1, 0); send(1, 0); send(1, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_now_valid", bus_m.m_valid, 1'b0);
    chk("rst_now_ready", bus_m.s_ready, 1'b0);
    clear_model();
    step();
    rst = 1'b0;
    idle();
    send(0, 0); send(0, 0); send(0, 0); send(0, 0); send(1, 1);
    chk("post_rst_msb", bus_m.m_data, 5'b00001);
    chk("post_rst_lsb", bus_l.m_data, 5'b10000);
    chk("post_rst_err", bus_m.m_err, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(3) != 0);
      s_bit   = $urandom_range(1) != 0;
      s_last  = ($urandom_range(5) == 0);
      m_ready = ($urandom_range(2) != 0);
      step();
    end

    m_ready = 1'b1;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
